fifo_burst_drain: RTL and testbench

- Consumer-side engine for the team's async-read / sync-write fifo. Drives the fifo's ren, samples rdata combinationally and forwards the data words downstream on a valid/ready stream.
- Drains in fixed-length bursts once enough words are buffered; a flush request drains a partial burst.
- Sits between the fifo's read side and a downstream packetiser/serialiser.

---
 rtl/fifo_burst_drain.sv | 155 +++++++++++++++
 tb/tb_fifo_burst_drain.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drain.sv
// Burst drain engine: pops the fifo in fixed bursts (or a flushed partial burst) into a 2-entry skid buffer.
// Latency: start condition seen in IDLE at cycle k -> first pop at k+1 -> out_valid at k+2; 1 word/cycle sustained.
// Backpressure: out_ready low fills the skid buffer; pops stop while it holds 2 words and no transfer is happening.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   fifo_empty, fifo_count     fifo status (count is ADDR_BITS+1 bits)
//   fifo_rdata, fifo_ren       async-read head word; read enable pops the head at the next posedge
//   flush                      level request to drain a partial burst
//   out_valid/out_data/out_ready  downstream valid/ready stream
//   busy                       high whenever the engine is not IDLE
//   out_last                   (only with LAST_FLAG_EN defined) marks the final word of each burst
module fifo_burst_drain #(
  parameter int MAX_DATA  = 16,
  parameter int ADDR_BITS = 5,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [ADDR_BITS:0]   fifo_count,
  input  logic [7:0]           fifo_rdata,
  output logic                 fifo_ren,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
`ifdef LAST_FLAG_EN
  output logic                 out_last,
`endif
  output logic                 busy
);

  localparam int CW = ADDR_BITS + 1;
  // A burst can never be longer than the fifo can hold.
  localparam int LOAD_MAX = (BURST_LEN < MAX_DATA) ? BURST_LEN : MAX_DATA;
  localparam logic [CW-1:0] BURST_W = CW'(BURST_LEN);
  localparam logic [CW-1:0] LOAD_W  = CW'(LOAD_MAX);

`ifdef LAST_FLAG_EN
  localparam int EW = 9;  // bit 8 marks the last word of a burst
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  beats_left_q, beats_left_d;
  logic [1:0]     occ_q, occ_d;
  logic [EW-1:0]  buf0_q, buf0_d;   // head entry
  logic [EW-1:0]  buf1_q, buf1_d;   // second entry
  logic [EW-1:0]  push_entry;
  logic           transfer;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q[7:0];
  assign transfer  = out_valid && out_ready;
  assign busy      = (state_q != IDLE);

`ifdef LAST_FLAG_EN
  assign out_last   = out_valid && buf0_q[8];
  assign push_entry = {(beats_left_q == CW'(1)), fifo_rdata};
`else
  assign push_entry = fifo_rdata;
`endif

  // Never pop an empty fifo: its read-while-empty behaviour would skip a slot.
  // A full skid buffer can still accept a word when the head leaves this cycle.
  assign fifo_ren = (state_q == BURST) && !fifo_empty && (beats_left_q != '0) &&
                    ((occ_q != 2'd2) || transfer);

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    occ_d        = occ_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;

    case (state_q)
      IDLE: begin
        // The count threshold wins over flush; flush on an empty fifo does nothing.
        if (fifo_count >= BURST_W) begin
          state_d      = BURST;
          beats_left_d = BURST_W;
        end else if (flush && (fifo_count != '0)) begin
          state_d      = BURST;
          beats_left_d = (fifo_count > LOAD_W) ? LOAD_W : fifo_count;
        end
      end
      BURST: begin
        // Waits here indefinitely if the fifo runs dry mid-burst.
        if (fifo_ren) begin
          beats_left_d = beats_left_q - CW'(1);
          if (beats_left_q == CW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      default: ;
    endcase

    // Skid buffer: in-order, head in buf0.
    case ({fifo_ren, transfer})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = push_entry;
        end else begin
          buf1_d = push_entry;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Push and pop together: occupancy unchanged, queue shifts by one.
        if (occ_q == 2'd1) begin
          buf0_d = push_entry;
        end else begin
          buf0_d = buf1_q;
          buf1_d = push_entry;
        end
      end
      default: ;
    endcase

    // Leave DRAIN as soon as the buffer is (or is about to be) empty.
    if ((state_q == DRAIN) && (occ_d == 2'd0)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      occ_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Testbench for fifo_burst_drain: behavioural fifo, scoreboard of pushed words and a burst-length model.
module tb_fifo_burst_drain;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_vld = 1'b0;
  logic [7:0] push_dat = 8'h00;
  logic       empty_glitch = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       fifo_empty, fifo_ren, out_valid, busy;
  logic [5:0] fifo_count;
  logic [7:0] fifo_rdata, out_data;
`ifdef LAST_FLAG_EN
  logic       out_last;
`endif

  always #5 clk = ~clk;

  // Behavioural async-read / sync-write fifo (not reset by the engine's reset).
  logic [7:0]  mem [64];
  logic [31:0] wr_cnt = 0;
  logic [31:0] rd_cnt = 0;
  always @(posedge clk) begin
    if (push_vld) begin
      mem[wr_cnt[5:0]] <= push_dat;
      wr_cnt <= wr_cnt + 1;
    end
    if (fifo_ren) rd_cnt <= rd_cnt + 1;
  end
  assign fifo_count = 6'(wr_cnt - rd_cnt);
  assign fifo_empty = (wr_cnt == rd_cnt) || empty_glitch;
  assign fifo_rdata = mem[rd_cnt[5:0]];

  fifo_burst_drain #(.MAX_DATA(16), .ADDR_BITS(5), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef LAST_FLAG_EN
    .out_last(out_last),
`endif
    .busy(busy)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state (owned by the monitor).
  logic [7:0] exp_q [$];
  bit         last_q [$];
  int         burst_len = 0, pops = 0, pred = 0, bursts = 0;
  bit         prev_idle = 1, prev_busy = 0, prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  bit         mon_en = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      // Words already popped into the engine are lost on reset; the fifo keeps the rest.
      while (exp_q.size() > int'(fifo_count)) void'(exp_q.pop_front());
      last_q.delete();
      prev_idle = 1; prev_busy = 0; prev_stall = 0; pred = 0; pops = 0; burst_len = 0;
    end else begin
      chk("ren_while_empty", {31'd0, fifo_ren && fifo_empty}, 0);
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 1);
        chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (prev_idle) begin
        chk("burst_start", {31'd0, busy}, {31'd0, pred != 0});
        if (busy) begin
          burst_len = pred; pops = 0; bursts++;
        end
      end
      if (prev_busy && !busy) chk("burst_pops", pops, burst_len);
      if (!busy) begin
        chk("ren_idle", {31'd0, fifo_ren}, 0);
        if (int'(fifo_count) >= BL) pred = BL;
        else if (flush && fifo_count != 0) pred = int'(fifo_count);
        else pred = 0;
      end else if (fifo_ren) begin
        chk("ren_after_burst", {31'd0, pops < burst_len}, 1);
        pops++;
        last_q.push_back(pops == burst_len);
      end
      if (out_valid && out_ready) begin
        chk("scoreboard_nonempty", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
`ifdef LAST_FLAG_EN
        if (last_q.size() != 0) chk("out_last", {31'd0, out_last}, {31'd0, last_q.pop_front()});
`endif
      end
`ifdef LAST_FLAG_EN
      if (!out_valid) chk("out_last_qual", {31'd0, out_last}, 0);
`endif
      if (push_vld) exp_q.push_back(push_dat);
      prev_idle  = !busy;
      prev_busy  = busy;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d);
    push_vld = 1'b1;
    push_dat = d;
    cyc();
    push_vld = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    out_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < maxc) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, n < maxc}, 1);
  endtask

  initial begin
    int b0;
    int n;
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_fifo_ren", {31'd0, fifo_ren}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
`ifdef LAST_FLAG_EN
    chk("rst_out_last", {31'd0, out_last}, 0);
`endif
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    mon_en = 1;

    // Full burst with exact timing
    out_ready = 1'b1;
    b0 = bursts;
    push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
    @(negedge clk);
    chk("full_count", {26'd0, fifo_count}, 4);
    chk("full_idle", {31'd0, busy}, 0);
    cyc(); @(negedge clk);
    chk("full_ren_k1", {31'd0, fifo_ren}, 1);
    chk("full_busy_k1", {31'd0, busy}, 1);
    chk("full_valid_k1", {31'd0, out_valid}, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); @(negedge clk);
      chk("full_valid", {31'd0, out_valid}, 1);
      chk("full_data", {24'd0, out_data}, 32'h11 * (i + 1));
      chk("full_ren", {31'd0, fifo_ren}, (i < 3) ? 1 : 0);
    end
    cyc(); @(negedge clk);
    chk("full_busy_end", {31'd0, busy}, 0);
    chk("full_valid_end", {31'd0, out_valid}, 0);
    chk("full_bursts", bursts - b0, 1);

    // Backpressure
    out_ready = 1'b0;
    push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
    for (int i = 0; i < 6; i++) cyc();
    @(negedge clk);
    chk("bp_count", {26'd0, fifo_count}, 2);
    chk("bp_valid", {31'd0, out_valid}, 1);
    chk("bp_data", {24'd0, out_data}, 32'h11);
    chk("bp_ren", {31'd0, fifo_ren}, 0);
    drain("bp_drain_timeout", 40);

    // Flush partial
    b0 = bursts;
    push1(8'hA0); push1(8'hA1); push1(8'hA2);
    cyc(); cyc(); @(negedge clk);
    chk("fl_wait_idle", {31'd0, busy}, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain("fl_drain_timeout", 40);
    chk("fl_count", {26'd0, fifo_count}, 0);
    chk("fl_bursts", bursts - b0, 1);

    // Flush on empty fifo is ignored
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      chk("fl_empty_busy", {31'd0, busy}, 0);
      chk("fl_empty_ren", {31'd0, fifo_ren}, 0);
    end
    flush = 1'b0;

    // Empty-flag glitch stalls the burst
    push1(8'hC0); push1(8'hC1); push1(8'hC2); push1(8'hC3);
    empty_glitch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      chk("gl_ren", {31'd0, fifo_ren}, 0);
      chk("gl_busy", {31'd0, busy}, 1);
    end
    empty_glitch = 1'b0;
    drain("gl_drain_timeout", 40);

    // Back-to-back: 8 continuous pushes -> two bursts
    b0 = bursts;
    for (int i = 0; i < 8; i++) push1(8'(8'h60 + i));
    drain("b2b_drain_timeout", 60);
    chk("b2b_bursts", bursts - b0, 2);

    // Reset mid-burst with the skid buffer full
    out_ready = 1'b0;
    push1(8'h55); push1(8'h56); push1(8'h57); push1(8'h58);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("rm_full_valid", {31'd0, out_valid}, 1);
    cyc();
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", {31'd0, out_valid}, 0);
    chk("rm_busy", {31'd0, busy}, 0);
    chk("rm_ren", {31'd0, fifo_ren}, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    mon_en = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      chk("rm_no_stale", {31'd0, out_valid}, 0);
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin cyc(); n++; end
    @(negedge clk);
    chk("rm_first_word", {24'd0, out_data}, 32'h57);
    drain("rm_drain_timeout", 40);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      push_vld  = (fifo_count < 6'd16) && ($urandom_range(0, 1) == 1);
      push_dat  = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 9) == 0);
      cyc();
    end
    push_vld = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while ((busy || fifo_count != 0 || exp_q.size() != 0) && n < 300) begin cyc(); n++; end
    flush = 1'b0;
    chk("rnd_drain_timeout", {31'd0, n < 300}, 1);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
